dlsc_pcie_s6_outbound_cpl: RTL and testbench
============================================

# dlsc_pcie_s6_outbound_cpl

Inbound completion parser for the Spartan-6 PCIe outbound (FPGA-as-requester) path. It consumes the 32-bit receive TLP stream from the core, decodes Cpl/CplD headers into a single registered header record for the read tracker, and streams CplD payload to the read data buffer. It counts payload against the header length and drops non-completion TLPs. Depending on configuration, it also drops completions addressed to another requester.

## Interface
Parameters:
- TAG, 5, tag width; must match the tag width used for outbound read requests.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- tlp_ready  out  1  TLP input accept
- tlp_valid  in  1  TLP input word valid
- tlp_data  in  32  TLP input word, header DW0 first
- tlp_last  in  1  final word of TLP
- cpl_h_ready  in  1  header accept
- cpl_h_valid  out  1  header valid
- cpl_h_tag  out  TAG  tag, DW2[8+:TAG]
- cpl_h_len  out  10  payload DWs, 0 means 1024 (forced 0 for Cpl without data)
- cpl_h_bytes  out  12  remaining byte count, DW1[11:0]
- cpl_h_addr  out  5  lower address [6:2], DW2[6:2]
- cpl_h_status  out  3  completion status, DW1[15:13]
- cpl_h_poison  out  1  EP bit, DW0[14]
- cpl_d_ready  in  1  data accept
- cpl_d_valid  out  1  data valid
- cpl_d_data  out  32  payload word
- cpl_d_last  out  1  final payload word of this completion
- err_unexpected  out  1  one-cycle pulse: completion dropped on requester ID
- err_malformed  out  1  one-cycle pulse: length and tlp_last disagree, or non-completion TLP dropped
- bus_number  in  8  own bus number
- dev_number  in  5  own device number
- func_number  in  3  own function number

## Operation
State machine: ST_H0, ST_H1, ST_H2, ST_DATA, ST_DROP. State advances only on the tlp_ready && tlp_valid handshake.
- **ST_H0**
  - Capture fmt[30], poison[14] and len[9:0].
  - DW0[30:24] is 7'b0001010 (Cpl) or 7'b1001010 (CplD): go to ST_H1.
  - Otherwise: pulse err_malformed, then go to ST_DROP, or stay in ST_H0 if tlp_last.
- **ST_H1**
  - Capture status and byte count.
  - Go to ST_H2.
- **ST_H2**
  - Capture tag and lower address; check requester ID DW2[31:16] against {bus,dev,func} (see Configuration).
  - Accepted completion: load the header register.
    - CplD goes to ST_DATA.
    - Cpl goes to ST_H0.
  - Rejected completion: pulse err_unexpected; the header register is not loaded. Go to ST_DROP, or to ST_H0 if tlp_last.
- **ST_DATA**
  - Pass-through: cpl_d_valid = tlp_valid, cpl_d_data = tlp_data, tlp_ready = cpl_d_ready.
  - A 10-bit down-counter is loaded with len (0 loads 1024).
  - cpl_d_last = (count==1) || tlp_last.
  - On the cpl_d_last beat: go to ST_H0.
  - If the count and tlp_last do not coincide: pulse err_malformed.
  - Count exhausted before tlp_last: go to ST_DROP.
- **ST_DROP**
  - tlp_ready = 1; words are discarded.
  - Go to ST_H0 on tlp_last.

Other rules:
- tlp_last on H0 or H1 of a valid completion (truncated header): pulse err_malformed, return to ST_H0, no header is emitted.
- Header register holds a single entry:
  - cpl_h_valid clears on cpl_h_ready.
  - In ST_H0, tlp_ready = !cpl_h_valid. A new TLP does not start while a header is pending.
  - ST_H1 and ST_H2 always have tlp_ready = 1.

## Timing
- Reset values:
  - state ST_H0
  - cpl_h_valid 0, all cpl_h_* fields 0
  - err pulses 0
  - tlp_ready 1 in ST_H0
  - cpl_d_valid 0
- Header latency: cpl_h_valid rises the cycle after the DW2 handshake. Payload DW3 may be presented in that same cycle.
- Data path has zero latency (combinational). Throughput is one word per cycle; minimum TLP spacing is none.
- Header register is written only when empty, so a pending header is never overwritten. The ST_H0 stall guarantees this.
- Reset mid-TLP returns to ST_H0 and discards the partial TLP. The remaining words are then parsed as a header; upstream rst covers both ends.

## Configuration
- DLSC_PCIE_S6_CPL_REQID_CHECK_EN
  - Defined: DW2[31:16] must equal {bus_number, dev_number, func_number}; a mismatch is dropped with err_unexpected.
  - Undefined: the requester ID is ignored, bus/dev/func ports are unused, and err_unexpected is tied 0.

## Test plan
- CplD len=4, tag=5'h03, status 0, byte count 16, lower addr 0x00 -> one header (len 4, bytes 16, tag 3), then 4 data words with cpl_d_last on the 4th.
- Cpl status=3'b001 (UR), tlp_last on DW2 -> header with len 0, status 1; no data beats.
- MWr TLP (DW0[30:24]=7'b1000000), 3 words -> err_malformed pulse, no header, all 3 words consumed.
- CplD len=2, tlp_last on the first data word -> cpl_d_last on word 1, err_malformed pulse, next TLP parsed normally.
- Two back-to-back CplDs with cpl_h_ready held 0 for 10 cycles -> tlp_ready 0 at the second DW0 until the first header is accepted; both delivered in order.
- Check enabled, requester ID 16'h0108 versus own 16'h0100 -> err_unexpected pulse, TLP dropped, no header.

Source files
------------

// File: rtl/dlsc_pcie_s6_outbound_cpl_if.sv
// Completion-parser bus bundle: receive TLP stream in, completion header
// record out, completion payload stream out.
//   tlp_*    : 32-bit receive TLP words (header DW0 first), valid/ready
//   cpl_h_*  : decoded completion header record, valid/ready
//   cpl_d_*  : completion payload words, valid/ready, last marks final word
// modport slave  : the completion parser (consumes TLPs, produces cpl_h/cpl_d)
// modport master : the surrounding logic (produces TLPs, consumes cpl_h/cpl_d)
interface dlsc_pcie_s6_outbound_cpl_if #(
    parameter int unsigned TAG = 5
);
    logic           tlp_ready;
    logic           tlp_valid;
    logic [31:0]    tlp_data;
    logic           tlp_last;

    logic           cpl_h_ready;
    logic           cpl_h_valid;
    logic [TAG-1:0] cpl_h_tag;
    logic [9:0]     cpl_h_len;
    logic [11:0]    cpl_h_bytes;
    logic [4:0]     cpl_h_addr;
    logic [2:0]     cpl_h_status;
    logic           cpl_h_poison;

    logic           cpl_d_ready;
    logic           cpl_d_valid;
    logic [31:0]    cpl_d_data;
    logic           cpl_d_last;

    modport slave (
        output tlp_ready,
        input  tlp_valid, tlp_data, tlp_last,
        input  cpl_h_ready,
        output cpl_h_valid, cpl_h_tag, cpl_h_len, cpl_h_bytes,
               cpl_h_addr, cpl_h_status, cpl_h_poison,
        input  cpl_d_ready,
        output cpl_d_valid, cpl_d_data, cpl_d_last
    );

    modport master (
        input  tlp_ready,
        output tlp_valid, tlp_data, tlp_last,
        output cpl_h_ready,
        input  cpl_h_valid, cpl_h_tag, cpl_h_len, cpl_h_bytes,
               cpl_h_addr, cpl_h_status, cpl_h_poison,
        output cpl_d_ready,
        input  cpl_d_valid, cpl_d_data, cpl_d_last
    );
endinterface

// File: rtl/dlsc_pcie_s6_outbound_cpl.sv
// Inbound completion parser for the Spartan-6 PCIe requester path.
// Decodes Cpl/CplD headers from the 32-bit receive TLP stream into a single
// registered header record, passes CplD payload straight through to the
// read data buffer, counts payload against the header length and drops
// non-completion TLPs.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   cif (slave)     : tlp_* input stream, cpl_h_* header record, cpl_d_* payload
//   err_unexpected  : one-cycle pulse, completion dropped on requester ID
//   err_malformed   : one-cycle pulse, length/tlp_last disagreement or
//                     non-completion TLP dropped
//   bus/dev/func_number : own requester ID
// Build option: define DLSC_PCIE_S6_CPL_REQID_CHECK_EN to drop completions
// whose requester ID differs from {bus_number, dev_number, func_number};
// otherwise the requester ID is ignored and err_unexpected stays 0.
module dlsc_pcie_s6_outbound_cpl #(
    parameter int unsigned TAG = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    dlsc_pcie_s6_outbound_cpl_if.slave    cif,
    output logic                          err_unexpected,
    output logic                          err_malformed,
    input  logic [7:0]                    bus_number,
    input  logic [4:0]                    dev_number,
    input  logic [2:0]                    func_number
);

    localparam int unsigned LEN_W = 10;

    typedef enum logic [2:0] {
        ST_H0,
        ST_H1,
        ST_H2,
        ST_DATA,
        ST_DROP
    } state_t;

    state_t             state_q, state_d;

    logic               cpld_q;
    logic               poison_q;
    logic [LEN_W-1:0]   len_q;
    logic [2:0]         status_q;
    logic [11:0]        bytes_q;
    logic [LEN_W-1:0]   count_q;

    logic               h_valid_q;
    logic [TAG-1:0]     h_tag_q;
    logic [LEN_W-1:0]   h_len_q;
    logic [11:0]        h_bytes_q;
    logic [4:0]         h_addr_q;
    logic [2:0]         h_status_q;
    logic               h_poison_q;

    logic               err_unexp_q;
    logic               err_malf_q;

    logic               tlp_ready_c;
    logic               xfer_c;
    logic               is_cpl_c;
    logic               reqid_ok_c;
    logic               count_one_c;
    logic               d_last_c;
    logic               hdr_load_c;
    logic               err_malf_c;
    logic               err_unexp_c;

    // Requester ID acceptance
`ifdef DLSC_PCIE_S6_CPL_REQID_CHECK_EN
    assign reqid_ok_c = (cif.tlp_data[31:16] == {bus_number, dev_number, func_number});
`else
    logic unused_reqid_c;
    assign unused_reqid_c = ^{bus_number, dev_number, func_number};
    assign reqid_ok_c     = 1'b1;
`endif

    // Cpl (no data) or CplD format/type in DW0[30:24]
    assign is_cpl_c    = (cif.tlp_data[30:24] == 7'b0001010) ||
                         (cif.tlp_data[30:24] == 7'b1001010);
    assign count_one_c = (count_q == LEN_W'(1));

    // Input acceptance; H0 stalls while a header is still pending
    always_comb begin
        tlp_ready_c = 1'b0;
        case (state_q)
            ST_H0:   tlp_ready_c = !h_valid_q;
            ST_H1:   tlp_ready_c = 1'b1;
            ST_H2:   tlp_ready_c = 1'b1;
            ST_DATA: tlp_ready_c = cif.cpl_d_ready;
            ST_DROP: tlp_ready_c = 1'b1;
            default: tlp_ready_c = 1'b0;
        endcase
    end

    assign xfer_c   = tlp_ready_c && cif.tlp_valid;
    assign d_last_c = (state_q == ST_DATA) && (count_one_c || cif.tlp_last);

    // Zero-latency payload pass-through
    assign cif.tlp_ready   = tlp_ready_c;
    assign cif.cpl_d_valid = (state_q == ST_DATA) && cif.tlp_valid;
    assign cif.cpl_d_data  = cif.tlp_data;
    assign cif.cpl_d_last  = d_last_c;

    // Next-state and event decode
    always_comb begin
        state_d     = state_q;
        hdr_load_c  = 1'b0;
        err_malf_c  = 1'b0;
        err_unexp_c = 1'b0;
        if (xfer_c) begin
            case (state_q)
                ST_H0: begin
                    if (!is_cpl_c) begin
                        err_malf_c = 1'b1;
                        state_d    = cif.tlp_last ? ST_H0 : ST_DROP;
                    end else if (cif.tlp_last) begin
                        err_malf_c = 1'b1;
                        state_d    = ST_H0;
                    end else begin
                        state_d    = ST_H1;
                    end
                end
                ST_H1: begin
                    if (cif.tlp_last) begin
                        err_malf_c = 1'b1;
                        state_d    = ST_H0;
                    end else begin
                        state_d    = ST_H2;
                    end
                end
                ST_H2: begin
                    if (!reqid_ok_c) begin
                        err_unexp_c = 1'b1;
                        state_d     = cif.tlp_last ? ST_H0 : ST_DROP;
                    end else if (cpld_q && cif.tlp_last) begin
                        // CplD without any payload word: no header, it would never complete
                        err_malf_c  = 1'b1;
                        state_d     = ST_H0;
                    end else begin
                        hdr_load_c  = 1'b1;
                        state_d     = cpld_q ? ST_DATA : ST_H0;
                    end
                end
                ST_DATA: begin
                    if (count_one_c && !cif.tlp_last) begin
                        err_malf_c = 1'b1;
                        state_d    = ST_DROP;
                    end else if (cif.tlp_last) begin
                        err_malf_c = !count_one_c;
                        state_d    = ST_H0;
                    end
                end
                ST_DROP: begin
                    if (cif.tlp_last) begin
                        state_d = ST_H0;
                    end
                end
                default: state_d = ST_H0;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_H0;
        end else begin
            state_q <= state_d;
        end
    end

    // Header field capture and payload down-counter (length 0 means 1024)
    always_ff @(posedge clk) begin
        if (rst) begin
            cpld_q   <= 1'b0;
            poison_q <= 1'b0;
            len_q    <= '0;
            status_q <= '0;
            bytes_q  <= '0;
            count_q  <= '0;
        end else begin
            if (xfer_c && state_q == ST_H0) begin
                cpld_q   <= cif.tlp_data[30];
                poison_q <= cif.tlp_data[14];
                len_q    <= cif.tlp_data[9:0];
            end
            if (xfer_c && state_q == ST_H1) begin
                status_q <= cif.tlp_data[15:13];
                bytes_q  <= cif.tlp_data[11:0];
            end
            if (hdr_load_c) begin
                count_q <= len_q;
            end else if (xfer_c && state_q == ST_DATA) begin
                count_q <= count_q - LEN_W'(1);
            end
        end
    end

    // Single-entry header register
    always_ff @(posedge clk) begin
        if (rst) begin
            h_valid_q  <= 1'b0;
            h_tag_q    <= '0;
            h_len_q    <= '0;
            h_bytes_q  <= '0;
            h_addr_q   <= '0;
            h_status_q <= '0;
            h_poison_q <= 1'b0;
        end else if (hdr_load_c) begin
            h_valid_q  <= 1'b1;
            h_tag_q    <= cif.tlp_data[8 +: TAG];
            h_len_q    <= cpld_q ? len_q : LEN_W'(0);
            h_bytes_q  <= bytes_q;
            h_addr_q   <= cif.tlp_data[6:2];
            h_status_q <= status_q;
            h_poison_q <= poison_q;
        end else if (cif.cpl_h_ready) begin
            h_valid_q  <= 1'b0;
        end
    end

    // Error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            err_unexp_q <= 1'b0;
            err_malf_q  <= 1'b0;
        end else begin
            err_unexp_q <= err_unexp_c;
            err_malf_q  <= err_malf_c;
        end
    end

    assign cif.cpl_h_valid  = h_valid_q;
    assign cif.cpl_h_tag    = h_tag_q;
    assign cif.cpl_h_len    = h_len_q;
    assign cif.cpl_h_bytes  = h_bytes_q;
    assign cif.cpl_h_addr   = h_addr_q;
    assign cif.cpl_h_status = h_status_q;
    assign cif.cpl_h_poison = h_poison_q;
    assign err_unexpected   = err_unexp_q;
    assign err_malformed    = err_malf_q;

endmodule

// File: tb/tb_dlsc_pcie_s6_outbound_cpl.sv
module tb_dlsc_pcie_s6_outbound_cpl;

    localparam int unsigned TAG = 5;

    typedef struct packed {
        logic [TAG-1:0] tag;
        logic [9:0]     len;
        logic [11:0]    bytes;
        logic [4:0]     addr;
        logic [2:0]     status;
        logic           poison;
    } hdr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_unexpected, err_malformed;
    logic [7:0] bus_number  = 8'h01;
    logic [4:0] dev_number  = 5'h00;
    logic [2:0] func_number = 3'h0;
    localparam logic [15:0] OWN_ID = 16'h0100;

    dlsc_pcie_s6_outbound_cpl_if #(.TAG(TAG)) cif();

    dlsc_pcie_s6_outbound_cpl #(.TAG(TAG)) dut (
        .clk            (clk),
        .rst            (rst),
        .cif            (cif),
        .err_unexpected (err_unexpected),
        .err_malformed  (err_malformed),
        .bus_number     (bus_number),
        .dev_number     (dev_number),
        .func_number    (func_number)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference model state
    logic [31:0] tlp_q[$];
    hdr_t        exp_h[$];
    logic [32:0] exp_d[$];
    int exp_malf = 0, exp_unexp = 0;
    int got_malf = 0, got_unexp = 0;
    int n_hdr = 0, n_data = 0;
    hdr_t        last_hdr;
    logic [32:0] last_d;
    hdr_t        hg;
    logic [32:0] dg;
    bit          hold_h = 1'b0;

    // Output sinks with random back-pressure
    always @(posedge clk) begin
        #1;
        cif.cpl_h_ready = hold_h ? 1'b0 : ($urandom_range(0, 3) != 0);
        cif.cpl_d_ready = ($urandom_range(0, 3) != 0);
    end

    // Compare process: every header/data handshake and every error pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (err_malformed)  got_malf++;
            if (err_unexpected) got_unexp++;
            if (cif.cpl_h_valid && cif.cpl_h_ready) begin
                hg = {cif.cpl_h_tag, cif.cpl_h_len, cif.cpl_h_bytes,
                      cif.cpl_h_addr, cif.cpl_h_status, cif.cpl_h_poison};
                n_hdr++;
                last_hdr = hg;
                if (exp_h.size() == 0) check("hdr_unexpected", 64'(hg), 64'(0));
                else check("hdr", 64'(hg), 64'(exp_h.pop_front()));
            end
            if (cif.cpl_d_valid && cif.cpl_d_ready) begin
                dg = {cif.cpl_d_last, cif.cpl_d_data};
                n_data++;
                last_d = dg;
                if (exp_d.size() == 0) check("data_unexpected", 64'(dg), 64'(0));
                else check("data", 64'(dg), 64'(exp_d.pop_front()));
            end
        end
    end

    // Behavioural model: whole-TLP outcome from the completion rules
    task automatic model_tlp();
        logic [31:0] dw0, dw1, dw2;
        logic [6:0]  typ;
        int n, lr, nd, beats;
        hdr_t h;
        n   = tlp_q.size();
        dw0 = tlp_q[0];
        typ = dw0[30:24];
        if (typ != 7'h0A && typ != 7'h4A) begin exp_malf++; return; end
        if (n < 3) begin exp_malf++; return; end
        dw1 = tlp_q[1];
        dw2 = tlp_q[2];
`ifdef DLSC_PCIE_S6_CPL_REQID_CHECK_EN
        if (dw2[31:16] != OWN_ID) begin exp_unexp++; return; end
`endif
        if (typ == 7'h4A && n == 3) begin exp_malf++; return; end
        h.tag    = dw2[8 +: TAG];
        h.len    = (typ == 7'h4A) ? dw0[9:0] : 10'd0;
        h.bytes  = dw1[11:0];
        h.addr   = dw2[6:2];
        h.status = dw1[15:13];
        h.poison = dw0[14];
        exp_h.push_back(h);
        if (typ == 7'h4A) begin
            lr    = (dw0[9:0] == 10'd0) ? 1024 : int'(dw0[9:0]);
            nd    = n - 3;
            beats = (nd < lr) ? nd : lr;
            for (int i = 0; i < beats; i++) exp_d.push_back({(i == beats - 1), tlp_q[3 + i]});
            if (nd != lr) exp_malf++;
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        int t = 0;
        cif.tlp_valid = 1'b1;
        cif.tlp_data  = d;
        cif.tlp_last  = l;
        forever begin
            @(negedge clk);
            if (cif.tlp_ready) begin
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            t++;
            if (t > 4000) begin
                check("tlp_ready_timeout", 64'(0), 64'(1));
                break;
            end
        end
        cif.tlp_valid = 1'b0;
        cif.tlp_data  = $urandom;
    endtask

    task automatic send_tlp();
        for (int i = 0; i < tlp_q.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                cif.tlp_valid = 1'b0;
                @(posedge clk); #1;
            end
            send_word(tlp_q[i], i == tlp_q.size() - 1);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_h.size() != 0 || exp_d.size() != 0) && t < 3000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 3000) check("drain_timeout", 64'(0), 64'(1));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic add_data(input int n);
        for (int i = 0; i < n; i++) tlp_q.push_back($urandom);
    endtask

    task automatic gen_random(input int kind);
        logic [31:0] dw0, dw1, dw2;
        int len, nd, nw;
        tlp_q.delete();
        dw0 = $urandom; dw0[31] = 1'b0;
        dw1 = $urandom;
        dw2 = $urandom; dw2[31:16] = OWN_ID;
        case (kind)
            0, 6: begin
                len = $urandom_range(1, 6); nd = len;
                dw0[30:24] = 7'h4A; dw0[9:0] = 10'(len);
                if (kind == 6) dw2[31:16] = 16'($urandom);
            end
            1: begin dw0[30:24] = 7'h0A; nd = 0; end
            3: begin
                len = $urandom_range(2, 6); nd = $urandom_range(1, len - 1);
                dw0[30:24] = 7'h4A; dw0[9:0] = 10'(len);
            end
            4: begin
                len = $urandom_range(1, 4); nd = len + $urandom_range(1, 3);
                dw0[30:24] = 7'h4A; dw0[9:0] = 10'(len);
            end
            default: nd = 0;
        endcase
        if (kind == 2) begin
            case ($urandom_range(0, 2))
                0:       dw0[30:24] = 7'h40;
                1:       dw0[30:24] = 7'h00;
                default: dw0[30:24] = 7'h0B;
            endcase
            nw = $urandom_range(1, 4);
        end else if (kind == 5) begin
            dw0[30:24] = ($urandom_range(0, 1) != 0) ? 7'h4A : 7'h0A;
            nw = $urandom_range(1, 2);
        end else begin
            nw = 3;
        end
        tlp_q.push_back(dw0);
        if (nw > 1) tlp_q.push_back(dw1);
        if (nw > 2) tlp_q.push_back(dw2);
        add_data(nd);
    endtask

    int m0, h0, d0, u0, stall;

    initial begin
        cif.tlp_valid   = 1'b0;
        cif.tlp_data    = '0;
        cif.tlp_last    = 1'b0;
        cif.cpl_h_ready = 1'b0;
        cif.cpl_d_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_h_valid", 64'(cif.cpl_h_valid), 64'(0));
        check("rst_h_fields", 64'({cif.cpl_h_tag, cif.cpl_h_len, cif.cpl_h_bytes,
              cif.cpl_h_addr, cif.cpl_h_status, cif.cpl_h_poison}), 64'(0));
        check("rst_tlp_ready", 64'(cif.tlp_ready), 64'(1));
        check("rst_d_valid", 64'(cif.cpl_d_valid), 64'(0));
        check("rst_errs", 64'({err_malformed, err_unexpected}), 64'(0));
        @(posedge clk); #1;

        // CplD len 4, tag 3, byte count 16
        tlp_q = '{32'h4A000004, 32'h00000010, 32'h01000300};
        add_data(4);
        model_tlp();
        check("t1_model_hdrs", 64'(exp_h.size()), 64'(1));
        check("t1_model_last", 64'(exp_d[3][32]), 64'(1));
        h0 = n_hdr; d0 = n_data; m0 = got_malf;
        send_tlp(); drain();
        check("t1_hdrs", 64'(n_hdr - h0), 64'(1));
        check("t1_tag", 64'(last_hdr.tag), 64'(3));
        check("t1_len", 64'(last_hdr.len), 64'(4));
        check("t1_bytes", 64'(last_hdr.bytes), 64'(16));
        check("t1_beats", 64'(n_data - d0), 64'(4));
        check("t1_malf", 64'(got_malf - m0), 64'(0));

        // Cpl, status UR, tlp_last on DW2
        tlp_q = '{32'h0A000005, 32'h00002004, 32'h01000700};
        model_tlp();
        h0 = n_hdr; d0 = n_data;
        send_tlp(); drain();
        check("t2_hdrs", 64'(n_hdr - h0), 64'(1));
        check("t2_len", 64'(last_hdr.len), 64'(0));
        check("t2_status", 64'(last_hdr.status), 64'(1));
        check("t2_tag", 64'(last_hdr.tag), 64'(7));
        check("t2_beats", 64'(n_data - d0), 64'(0));

        // MWr, 3 words: dropped
        tlp_q = '{32'h40000001, 32'h12345678, 32'h9abcdef0};
        model_tlp();
        h0 = n_hdr; m0 = got_malf;
        send_tlp(); drain();
        check("t3_hdrs", 64'(n_hdr - h0), 64'(0));
        check("t3_malf", 64'(got_malf - m0), 64'(1));

        // CplD len 2 ending on the first data word
        tlp_q = '{32'h4A000002, 32'h00000008, 32'h01000100, 32'hcafef00d};
        model_tlp();
        h0 = n_hdr; d0 = n_data; m0 = got_malf;
        send_tlp(); drain();
        check("t4_beats", 64'(n_data - d0), 64'(1));
        check("t4_last", 64'(last_d), 64'({1'b1, 32'hcafef00d}));
        check("t4_malf", 64'(got_malf - m0), 64'(1));
        tlp_q = '{32'h4A000001, 32'h00000004, 32'h01000200, 32'h00000042};
        model_tlp();
        send_tlp(); drain();
        check("t4_next_tag", 64'(last_hdr.tag), 64'(2));

        // Back-to-back CplDs with the header sink stalled
        hold_h = 1'b1;
        h0 = n_hdr;
        tlp_q = '{32'h4A000002, 32'h00000008, 32'h01000a00, 32'h11111111, 32'h22222222};
        model_tlp();
        send_tlp();
        tlp_q = '{32'h4A000001, 32'h00000004, 32'h01000b00, 32'h33333333};
        model_tlp();
        cif.tlp_valid = 1'b1; cif.tlp_data = tlp_q[0]; cif.tlp_last = 1'b0;
        stall = 0;
        repeat (10) begin
            @(negedge clk);
            if (!cif.tlp_ready) stall++;
        end
        check("t5_stall", 64'(stall), 64'(10));
        check("t5_pending", 64'(n_hdr - h0), 64'(0));
        @(posedge clk); #1;
        hold_h = 1'b0;
        send_tlp(); drain();
        check("t5_hdrs", 64'(n_hdr - h0), 64'(2));
        check("t5_tag", 64'(last_hdr.tag), 64'(5'h0b));

        // Requester ID 0108 versus own 0100
        tlp_q = '{32'h4A000001, 32'h00000004, 32'h01080400, 32'h55555555};
        model_tlp();
        h0 = n_hdr; u0 = got_unexp;
        send_tlp(); drain();
`ifdef DLSC_PCIE_S6_CPL_REQID_CHECK_EN
        check("t6_unexp", 64'(got_unexp - u0), 64'(1));
        check("t6_hdrs", 64'(n_hdr - h0), 64'(0));
`else
        check("t6_unexp", 64'(got_unexp - u0), 64'(0));
        check("t6_hdrs", 64'(n_hdr - h0), 64'(1));
`endif

        // CplD length field 0 = 1024 words
        tlp_q = '{32'h4A000000, 32'h00000000, 32'h01000c00};
        add_data(1024);
        model_tlp();
        d0 = n_data; m0 = got_malf;
        send_tlp(); drain();
        check("t7_len", 64'(last_hdr.len), 64'(0));
        check("t7_beats", 64'(n_data - d0), 64'(1024));
        check("t7_malf", 64'(got_malf - m0), 64'(0));

        // Randomized traffic
        for (int k = 0; k < 120; k++) begin
            gen_random($urandom_range(0, 6));
            model_tlp();
            send_tlp();
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        drain();

        check("end_hdr_queue", 64'(exp_h.size()), 64'(0));
        check("end_data_queue", 64'(exp_d.size()), 64'(0));
        check("end_malformed", 64'(got_malf), 64'(exp_malf));
        check("end_unexpected", 64'(got_unexp), 64'(exp_unexp));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
